// File: rtl/ball_ctrl.sv
// Ball motion controller: step-rate divider, wall/paddle/brick bounce and serve/lost sequencing.
// Build option BALL_CTRL_SPEEDUP_EN: each paddle bounce shortens the step period down to a floor.
//
// state | meaning
// IDLE  | ball held at origin, waiting for launch
// MOVE  | ball stepping once per period, bounces evaluated at each tick
// LOST  | one-cycle lost-ball pulse before returning to IDLE
module ball_ctrl #(
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int BALL_SIZE = 4,
  parameter int PADDLE_Y  = 440,
  parameter int PADDLE_W  = 40,
  parameter int TICK_DIV  = 833333,
  parameter int TICK_STEP = 50000,
  parameter int TICK_MIN  = 208333
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       launch,
  input  logic [9:0] paddle_x,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic       brick_hit,
  input  logic       brick_side,
  output logic       move_en,
  output logic       x_du,
  output logic       y_du,
  output logic       ball_rst,
  output logic       lost,
  output logic [1:0] state
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_MOVE = 2'b01;
  localparam logic [1:0] S_LOST = 2'b10;

  localparam int             CW     = $clog2(TICK_DIV + 1);
  localparam logic [CW-1:0]  P_DIV  = CW'(TICK_DIV);
  localparam logic [CW-1:0]  P_LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0]  ONE    = CW'(1);

  localparam logic [10:0] X_MAX   = 11'(SCREEN_W - BALL_SIZE);
  localparam logic [10:0] Y_MAX   = 11'(SCREEN_H - BALL_SIZE);
  localparam logic [10:0] PAD_ROW = 11'(PADDLE_Y - BALL_SIZE);
  localparam logic [10:0] BSZ     = 11'(BALL_SIZE);
  localparam logic [10:0] PW      = 11'(PADDLE_W);

  logic [1:0]    state_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt, reload;
  logic          flag_q, flag_nxt, side_q, side_nxt;
  logic          x_du_nxt, y_du_nxt, move_en_nxt, ball_rst_nxt, lost_nxt;
  logic [10:0]   bx, by, px;
  logic          tick, wall_x, ceil_hit, paddle_hit, floor_hit, flip_x, flip_y;

  assign bx = {1'b0, ball_x};
  assign by = {1'b0, ball_y};
  assign px = {1'b0, paddle_x};

  // Down-counter: loaded with period-1, tick at zero.
  assign tick       = (state == S_MOVE) && (cnt_q == '0);
  assign wall_x     = x_du ? (bx >= X_MAX) : (bx == 11'd0);
  assign ceil_hit   = !y_du && (by == 11'd0);
  assign paddle_hit = y_du && (by == PAD_ROW) && (bx + BSZ > px) && (bx < px + PW);
  assign floor_hit  = y_du && (by >= Y_MAX);
  // OR keeps a wall/paddle flip and a brick flip on the same axis to a single flip.
  assign flip_x     = wall_x | (flag_q & side_q);
  assign flip_y     = ceil_hit | paddle_hit | (flag_q & ~side_q);

`ifdef BALL_CTRL_SPEEDUP_EN
  localparam logic [CW-1:0] P_STEP = CW'(TICK_STEP);
  localparam logic [CW-1:0] P_MIN  = CW'(TICK_MIN);
  logic [CW-1:0] per_q, per_nxt;

  always_comb begin
    per_nxt = per_q;
    if (state == S_IDLE && launch)
      per_nxt = P_DIV;
    else if (tick && paddle_hit)
      per_nxt = (per_q - P_MIN > P_STEP) ? per_q - P_STEP : P_MIN;
  end

  always_ff @(posedge clk) begin
    if (reset) per_q <= P_DIV;
    else       per_q <= per_nxt;
  end

  assign reload = per_nxt - ONE;
`else
  assign reload = P_LAST;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (launch) state_nxt = S_MOVE;
      S_MOVE:  if (tick && floor_hit) state_nxt = S_LOST;
      S_LOST:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    x_du_nxt     = x_du;
    y_du_nxt     = y_du;
    move_en_nxt  = 1'b0;
    ball_rst_nxt = (state_nxt == S_IDLE);
    lost_nxt     = (state_nxt == S_LOST);
    cnt_nxt      = cnt_q;
    flag_nxt     = 1'b0;
    side_nxt     = side_q;
    case (state)
      S_IDLE: begin
        if (launch) begin
          x_du_nxt = 1'b1;
          y_du_nxt = 1'b1;
          cnt_nxt  = reload;
        end
      end
      S_MOVE: begin
        flag_nxt = flag_q | brick_hit;
        side_nxt = brick_hit ? brick_side : side_q;
        if (tick) begin
          x_du_nxt    = x_du ^ flip_x;
          y_du_nxt    = y_du ^ flip_y;
          move_en_nxt = !floor_hit;
          cnt_nxt     = reload;
          // The flag is consumed here; a pulse in the tick cycle itself waits for the next tick.
          flag_nxt    = brick_hit;
        end else begin
          cnt_nxt = cnt_q - ONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_du     <= 1'b1;
      y_du     <= 1'b1;
      move_en  <= 1'b0;
      ball_rst <= 1'b1;
      lost     <= 1'b0;
      cnt_q    <= '0;
      flag_q   <= 1'b0;
      side_q   <= 1'b0;
    end else begin
      x_du     <= x_du_nxt;
      y_du     <= y_du_nxt;
      move_en  <= move_en_nxt;
      ball_rst <= ball_rst_nxt;
      lost     <= lost_nxt;
      cnt_q    <= cnt_nxt;
      flag_q   <= flag_nxt;
      side_q   <= side_nxt;
    end
  end

endmodule

// File: tb/tb_ball_ctrl.sv
// Bench for ball_ctrl: directed serve/bounce/lost sequence plus random stimulus,
// all outputs compared every cycle against an edge-indexed behavioural model.
module tb_ball_ctrl;
`ifdef BALL_CTRL_SPEEDUP_EN
  localparam int TD = 10;
  localparam int TS = 3;
  localparam int TM = 5;
`else
  localparam int TD = 4;
  localparam int TS = 1;
  localparam int TM = 2;
`endif

  logic       clk, reset, launch, brick_hit, brick_side;
  logic [9:0] paddle_x, ball_x, ball_y;
  logic       move_en, x_du, y_du, ball_rst, lost;
  logic [1:0] state;

  ball_ctrl #(
    .SCREEN_W(640), .SCREEN_H(480), .BALL_SIZE(4), .PADDLE_Y(440), .PADDLE_W(40),
    .TICK_DIV(TD), .TICK_STEP(TS), .TICK_MIN(TM)
  ) dut (
    .clk(clk), .reset(reset), .launch(launch), .paddle_x(paddle_x),
    .ball_x(ball_x), .ball_y(ball_y), .brick_hit(brick_hit), .brick_side(brick_side),
    .move_en(move_en), .x_du(x_du), .y_du(y_du), .ball_rst(ball_rst),
    .lost(lost), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: phase 0 idle, 1 move, 2 lost; ticks scheduled by absolute edge number.
  int     m_phase, m_period;
  bit     m_x, m_y, m_move, m_lost, m_pend, m_pside;
  longint edge_n, m_next_tick;

  function automatic void model_tick();
    int  x, y, p;
    bit  wall, ceil_h, pad, floor_h;
    x = int'(ball_x);
    y = int'(ball_y);
    p = int'(paddle_x);
    wall    = m_x ? (x >= 640 - 4) : (x == 0);
    ceil_h  = !m_y && (y == 0);
    pad     = m_y && (y == 440 - 4) && (x + 4 > p) && (x < p + 40);
    floor_h = m_y && (y >= 480 - 4);
    if (wall || (m_pend && m_pside))    m_x = !m_x;
    if (ceil_h || pad || (m_pend && !m_pside)) m_y = !m_y;
`ifdef BALL_CTRL_SPEEDUP_EN
    if (pad) m_period = (m_period - TS > TM) ? m_period - TS : TM;
`endif
    m_next_tick = edge_n + m_period;
    m_pend = brick_hit;
    if (brick_hit) m_pside = brick_side;
    if (floor_h) begin
      m_phase = 2;
      m_lost  = 1;
    end else begin
      m_move = 1;
    end
  endfunction

  function automatic void model_edge();
    edge_n++;
    m_move = 0;
    m_lost = 0;
    if (reset) begin
      m_phase = 0; m_x = 1; m_y = 1; m_pend = 0; m_period = TD;
      return;
    end
    case (m_phase)
      0: if (launch) begin
        m_phase = 1; m_x = 1; m_y = 1; m_pend = 0; m_period = TD;
        m_next_tick = edge_n + TD;
      end
      1: begin
        if (edge_n == m_next_tick) model_tick();
        else if (brick_hit) begin
          m_pend  = 1;
          m_pside = brick_side;
        end
      end
      default: begin
        m_phase = 0;
        m_pend  = 0;
      end
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("state",    int'(state),    m_phase);
    check("x_du",     int'(x_du),     int'(m_x));
    check("y_du",     int'(y_du),     int'(m_y));
    check("move_en",  int'(move_en),  int'(m_move));
    check("lost",     int'(lost),     int'(m_lost));
    check("ball_rst", int'(ball_rst), int'(m_phase == 0));
  endtask

  task automatic wait_step();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(m_move || m_lost) && n < 60);
    if (!(m_move || m_lost)) begin
      tests++;
      fails++;
      $display("FAIL wait_step: no step or loss within %0d cycles", n);
    end
  endtask

  task automatic count_period(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!move_en && n < 60);
  endtask

  function automatic logic [9:0] pick_x();
    case ($urandom_range(0, 9))
      0: return 10'd0;
      1: return 10'd636;
      2: return 10'd639;
      3: return 10'd635;
      4: return 10'd96;
      5: return 10'd97;
      6: return 10'd139;
      7: return 10'd140;
      default: return 10'($urandom_range(0, 1023));
    endcase
  endfunction

  function automatic logic [9:0] pick_y();
    case ($urandom_range(0, 9))
      0: return 10'd0;
      1: return 10'd436;
      2: return 10'd476;
      3: return 10'd479;
      4: return 10'd435;
      default: return 10'($urandom_range(1, 470));
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1; launch = 0; brick_hit = 0; brick_side = 0;
    paddle_x = 10'd0; ball_x = 10'd300; ball_y = 10'd100;
    edge_n = 0; m_next_tick = 0;
    m_phase = 0; m_x = 1; m_y = 1; m_move = 0; m_lost = 0;
    m_pend = 0; m_pside = 0; m_period = TD;

    step(); step();
    check("rst_state",    int'(state), 0);
    check("rst_ball_rst", int'(ball_rst), 1);
    check("rst_x_du",     int'(x_du), 1);
    check("rst_y_du",     int'(y_du), 1);
    check("rst_move_en",  int'(move_en), 0);
    check("rst_lost",     int'(lost), 0);
    reset = 0;
    repeat (3) step();
    check("idle_state",    int'(state), 0);
    check("idle_ball_rst", int'(ball_rst), 1);

    launch = 1; step(); launch = 0;
    check("serve_state",    int'(state), 1);
    check("serve_ball_rst", int'(ball_rst), 0);
    count_period(n);
    check("first_step_delay", n, TD);
    launch = 1; step(); launch = 0;
    n = 1;
    while (!move_en && n < 60) begin
      step();
      n++;
    end
    check("relaunch_period", n, TD);
    check("relaunch_state", int'(state), 1);

    ball_x = 10'd636; wait_step(); check("right_wall", int'(x_du), 0);
    ball_x = 10'd0;   wait_step(); check("left_wall",  int'(x_du), 1);
    ball_x = 10'd300;

    paddle_x = 10'd100; ball_x = 10'd120; ball_y = 10'd436;
    wait_step(); check("paddle_hit", int'(y_du), 0);
    ball_y = 10'd0; wait_step(); check("ceiling", int'(y_du), 1);
    ball_y = 10'd436; ball_x = 10'd140;
    wait_step(); check("paddle_right_miss", int'(y_du), 1);
    ball_x = 10'd97;
    wait_step(); check("paddle_left_overlap", int'(y_du), 0);
    ball_y = 10'd0; wait_step();
    ball_y = 10'd100; ball_x = 10'd300;

    step(); brick_hit = 1; brick_side = 1; step(); brick_hit = 0;
    wait_step(); check("brick_flip_x", int'(x_du), 0);
    wait_step(); check("brick_no_reflip", int'(x_du), 0);
    ball_x = 10'd0;
    step(); brick_hit = 1; brick_side = 1; step(); brick_hit = 0;
    wait_step(); check("brick_wall_single", int'(x_du), 1);
    ball_x = 10'd300;

    ball_y = 10'd476; wait_step();
    check("floor_lost",    int'(lost), 1);
    check("floor_state",   int'(state), 2);
    check("floor_no_move", int'(move_en), 0);
    step();
    check("after_lost_pulse", int'(lost), 0);
    check("after_lost_state", int'(state), 0);
    check("after_lost_rst",   int'(ball_rst), 1);
    ball_y = 10'd100;

`ifdef BALL_CTRL_SPEEDUP_EN
    launch = 1; step(); launch = 0;
    count_period(n); check("sp_first", n, 10);
    paddle_x = 10'd100; ball_x = 10'd120; ball_y = 10'd436; count_period(n);
    ball_y = 10'd100; count_period(n); check("sp_period1", n, 7);
    ball_y = 10'd0;   count_period(n);
    ball_y = 10'd436; count_period(n);
    ball_y = 10'd100; count_period(n); check("sp_period2", n, 5);
    ball_y = 10'd0;   count_period(n);
    ball_y = 10'd436; count_period(n);
    ball_y = 10'd100; count_period(n); check("sp_period3", n, 5);
`endif

    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 299) == 0);
      launch     = ($urandom_range(0, 7) == 0);
      brick_hit  = ($urandom_range(0, 5) == 0);
      brick_side = 1'($urandom_range(0, 1));
      ball_x     = pick_x();
      ball_y     = pick_y();
      paddle_x   = ($urandom_range(0, 2) == 0) ? 10'($urandom_range(0, 1023)) : 10'd100;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ball_ctrl.md
Name: ball_ctrl

Overview:
- Motion controller directly upstream of the ball position counters; drives their step-enable and up/down direction inputs.
- Generates the ball step rate from a tick divider.
- Bounces the ball off the walls, the paddle and bricks by flipping the direction bits.
- Sequences the serve, play and lost-ball phases, and holds the position counters at origin (0,0) between serves.

Parameters:
- SCREEN_W, 640, playfield width in pixels
- SCREEN_H, 480, playfield height in pixels
- BALL_SIZE, 4, ball edge length in pixels
- PADDLE_Y, 440, top row of the paddle
- PADDLE_W, 40, paddle width in pixels
- TICK_DIV, 833333, clk cycles per ball step (60 Hz at 50 MHz); minimum 2
- TICK_STEP, 50000, period decrement per paddle bounce (SPEEDUP_EN only)
- TICK_MIN, 208333, floor on the step period (SPEEDUP_EN only)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- launch  in  1  serve request, level or pulse
- paddle_x  in  10  paddle left-edge x coordinate
- ball_x  in  10  current ball x, from the position counters
- ball_y  in  10  current ball y, from the position counters
- brick_hit  in  1  one-cycle pulse from the brick collision logic
- brick_side  in  1  0 = horizontal face hit (flip y); 1 = vertical face hit (flip x)
- move_en  out  1  one-cycle step pulse to the position counters
- x_du  out  1  1 = x increments, 0 = x decrements
- y_du  out  1  1 = y increments (down), 0 = y decrements
- ball_rst  out  1  active-high hold-at-origin for the position counters
- lost  out  1  one-cycle pulse when the ball passes the floor
- state  out  2  00 = IDLE, 01 = MOVE, 10 = LOST

Behaviour:
- Reset values: state = IDLE, x_du = 1, y_du = 1, move_en = 0, ball_rst = 1, lost = 0, tick counter = 0, brick flag clear. All outputs are registered.
- IDLE:
  - ball_rst = 1 and move_en = 0.
  - launch = 1 → MOVE on the next edge; x_du and y_du are set to 1 and the tick counter is cleared.
- MOVE:
  - ball_rst = 0. The tick counter runs 0..P-1 and wraps; P = TICK_DIV.
  - When the counter equals P-1 ("tick"), the collision rules below are evaluated and the direction registers are updated.
  - move_en is asserted on the following cycle, so every step uses the updated direction.
  - First move_en pulse occurs exactly P cycles after MOVE entry; period is P thereafter.
- Collision rules at tick (inputs are the current x, y, x_du, y_du):
  - Right wall: x_du = 1 and ball_x ≥ SCREEN_W-BALL_SIZE → x_du = 0.
  - Left wall: x_du = 0 and ball_x = 0 → x_du = 1.
  - Ceiling: y_du = 0 and ball_y = 0 → y_du = 1.
  - Paddle: y_du = 1, ball_y = PADDLE_Y-BALL_SIZE, ball_x+BALL_SIZE > paddle_x and ball_x < paddle_x+PADDLE_W → y_du = 0. Compares use 11-bit unsigned arithmetic; no wrap.
  - Floor: y_du = 1 and ball_y ≥ SCREEN_H-BALL_SIZE → LOST on the next edge; no move_en for that tick.
  - Brick: any brick_hit pulse in MOVE sets a sticky flag and latches brick_side; a later pulse overwrites the side. At tick, a set flag flips the selected axis, then the flag clears.
  - Same axis flagged by both a wall/paddle rule and the brick flag → flipped once only (the wall/paddle result wins).
  - Corner (x and y rules both true) → both bits flip.
- LOST:
  - Lasts exactly one cycle. lost = 1, move_en = 0, then IDLE (ball_rst = 1 from the next cycle).
- Ignored inputs:
  - launch in MOVE or LOST.
  - brick_hit outside MOVE; the flag is cleared on IDLE entry.
- Reset mid-operation returns all state to the reset values on the next edge, including any pending move_en.

Optional Feature:
- Macro: BALL_CTRL_SPEEDUP_EN
- Defined:
  - A step-period register P loads TICK_DIV on serve.
  - Each paddle bounce reduces P by TICK_STEP, saturating at TICK_MIN.
  - The new P applies from the next counter wrap.
- Undefined: P is the constant TICK_DIV; the TICK_STEP and TICK_MIN parameters are unused and no extra registers exist.

Test Plan (TICK_DIV = 4 unless stated):
- Reset for 2 cycles → state = 00, ball_rst = 1, x_du = 1, y_du = 1, move_en = 0, lost = 0; stays so with launch = 0.
- Pulse launch → state = 01 next edge, ball_rst = 0; move_en pulses 4 cycles after entry, then every 4 cycles; a second launch has no effect.
- ball_x = 636, x_du = 1, ball_y = 100 → x_du = 0 at the next tick. Then ball_x = 0 → x_du = 1.
- Paddle: paddle_x = 100, ball_x = 120, ball_y = 436, y_du = 1 → y_du = 0. ball_x = 140 → no flip. ball_x = 97 → flip.
- Floor: ball_y = 476, y_du = 1 → lost high for exactly 1 cycle with state = 10, no move_en; then state = 00 and ball_rst = 1.
- Brick:
  - brick_hit with side = 1 mid-period → x_du flips at the next tick only.
  - Same pulse with ball_x = 0, x_du = 0 → x_du = 1, a single flip.
  - With BALL_CTRL_SPEEDUP_EN, TICK_DIV = 10, TICK_STEP = 3, TICK_MIN = 5: three paddle bounces give periods 7, 5, 5.
